// File: rtl/trsq_pc_seq_if.sv
// Decoder-to-sequencer bundle for the TRSQ program-counter sequencer.
// The decoder side drives strobes and IRQ lines; the sequencer drives PC and status.
interface trsq_pc_seq_if #(
   parameter int ADDR_W      = 13,
   parameter int STACK_DEPTH = 4,
   parameter int NUM_IRQ     = 4
);
   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

   logic                halt_ip;
   logic                jmp_ip;
   logic [ADDR_W-1:0]   jmp_addr_ip;
   logic                skip_ip;
   logic                call_ip;
   logic                ret_ip;
   logic                reti_ip;
   logic [NUM_IRQ-1:0]  irq_ip;
   logic [NUM_IRQ-1:0]  irq_mask_ip;
   logic                clr_err_ip;
   logic [ADDR_W-1:0]   pc_op;
   logic [NUM_IRQ-1:0]  irq_ack_op;
   logic [NUM_IRQ-1:0]  in_service_op;
   logic [DEPTH_W-1:0]  depth_op;
   logic                stack_ovf_op;
   logic                stack_unf_op;

   modport master (
      output halt_ip, jmp_ip, jmp_addr_ip, skip_ip, call_ip, ret_ip, reti_ip,
             irq_ip, irq_mask_ip, clr_err_ip,
      input  pc_op, irq_ack_op, in_service_op, depth_op, stack_ovf_op, stack_unf_op
   );

   modport slave (
      input  halt_ip, jmp_ip, jmp_addr_ip, skip_ip, call_ip, ret_ip, reti_ip,
             irq_ip, irq_mask_ip, clr_err_ip,
      output pc_op, irq_ack_op, in_service_op, depth_op, stack_ovf_op, stack_unf_op
   );
endinterface

// File: rtl/trsq_pc_seq.sv
// TRSQ program-counter sequencer: fetch, jump, skip, halt, call/return and
// vectored, prioritised, nestable interrupts sharing one hardware return stack.
module trsq_pc_seq #(
   parameter int ADDR_W      = 13,
   parameter int STACK_DEPTH = 4,
   parameter int NUM_IRQ     = 4,
   parameter int VEC_BASE    = 4,
   parameter int VEC_STRIDE  = 4
) (
   input  logic            clk_ip,
   input  logic            reset_n_ip,
   trsq_pc_seq_if.slave    bus
);
   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
   localparam logic [DEPTH_W-1:0] FULL_D = DEPTH_W'(STACK_DEPTH);

   typedef logic [ADDR_W-1:0] addr_t;

   addr_t               pc;
   addr_t               stack_mem [STACK_DEPTH];
   logic [DEPTH_W-1:0]  depth;
   logic [NUM_IRQ-1:0]  irq_prev;
   logic [NUM_IRQ-1:0]  pend;
   logic [NUM_IRQ-1:0]  in_service;
   logic [NUM_IRQ-1:0]  irq_ack;
   logic                stack_ovf;
   logic                stack_unf;

   logic [NUM_IRQ-1:0]  irq_rise;
   logic [NUM_IRQ-1:0]  irq_oh;
   logic [NUM_IRQ-1:0]  take_oh;
   logic [NUM_IRQ-1:0]  isr_lowest;
   logic [NUM_IRQ-1:0]  isr_clr;
   logic                irq_found;
   logic                blocked;
   logic                stk_full;
   logic                stk_empty;
   logic                push;
   logic                pop;
   logic                set_ovf;
   logic                set_unf;
   addr_t               pc_inc1;
   addr_t               pc_inc2;
   addr_t               pc_nxt;
   addr_t               pop_val;
   addr_t               irq_vec;

   function automatic addr_t vec_addr(input int ch);
      return addr_t'(VEC_BASE + ch * VEC_STRIDE);
   endfunction

   always_comb begin
      irq_rise   = bus.irq_ip & ~irq_prev;
      stk_full   = (depth == FULL_D);
      stk_empty  = (depth == '0);
      pc_inc1    = pc + addr_t'(1);
      pc_inc2    = pc + addr_t'(2);
      isr_lowest = in_service & (~in_service + NUM_IRQ'(1));

      pop_val = '0;
      for (int k = 0; k < STACK_DEPTH; k++) begin
         if (depth == DEPTH_W'(k + 1)) pop_val = stack_mem[k];
      end

      // A channel is eligible only if it outranks every channel already in service.
      irq_found = 1'b0;
      blocked   = 1'b0;
      irq_oh    = '0;
      irq_vec   = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         blocked = blocked | in_service[i];
         if (!irq_found && !blocked && pend[i] && bus.irq_mask_ip[i]) begin
            irq_found = 1'b1;
            irq_oh[i] = 1'b1;
            irq_vec   = vec_addr(i);
         end
      end

      pc_nxt  = pc_inc1;
      push    = 1'b0;
      pop     = 1'b0;
      take_oh = '0;
      set_ovf = 1'b0;
      set_unf = 1'b0;
      isr_clr = '0;
      if (bus.jmp_ip) begin
         pc_nxt = bus.jmp_addr_ip;
      end else if (bus.call_ip) begin
         pc_nxt = bus.jmp_addr_ip;
         if (stk_full) set_ovf = 1'b1;
         else          push    = 1'b1;
      end else if (bus.ret_ip || bus.reti_ip) begin
         if (bus.reti_ip) isr_clr = isr_lowest;
         if (stk_empty) begin
            set_unf = 1'b1;
         end else begin
            pop    = 1'b1;
            pc_nxt = pop_val;
         end
      end else if (bus.skip_ip) begin
         pc_nxt = pc_inc2;
      end else if (irq_found && !stk_full) begin
         push    = 1'b1;
         take_oh = irq_oh;
         pc_nxt  = irq_vec;
      end else if (bus.halt_ip) begin
         pc_nxt = pc;
      end
   end

   always_ff @(posedge clk_ip or negedge reset_n_ip) begin
      if (!reset_n_ip) begin
         pc         <= '0;
         depth      <= '0;
         irq_prev   <= '0;
         pend       <= '0;
         in_service <= '0;
         irq_ack    <= '0;
         stack_ovf  <= 1'b0;
         stack_unf  <= 1'b0;
      end else begin
         pc         <= pc_nxt;
         irq_prev   <= bus.irq_ip;
         pend       <= (pend & ~take_oh) | irq_rise;
         in_service <= (in_service & ~isr_clr) | take_oh;
         irq_ack    <= take_oh;
         stack_ovf  <= set_ovf | (stack_ovf & ~bus.clr_err_ip);
         stack_unf  <= set_unf | (stack_unf & ~bus.clr_err_ip);
         if (push)     depth <= depth + DEPTH_W'(1);
         else if (pop) depth <= depth - DEPTH_W'(1);
      end
   end

   // Return-stack storage holds data only; occupancy is tracked by depth.
   always_ff @(posedge clk_ip) begin
      for (int k = 0; k < STACK_DEPTH; k++) begin
         if (push && depth == DEPTH_W'(k)) stack_mem[k] <= pc_inc1;
      end
   end

   assign bus.pc_op         = pc;
   assign bus.irq_ack_op    = irq_ack;
   assign bus.in_service_op = in_service;
   assign bus.depth_op      = depth;
   assign bus.stack_ovf_op  = stack_ovf;
   assign bus.stack_unf_op  = stack_unf;
endmodule
